// File: rtl/shift_line_sequencer.sv
// Sequencer for a tap shift line: divides the clock to a sample tick, accepts one
// streamed sample per tick, and drives shift-enable/data, fill tracking and zero flush.
module shift_line_sequencer #(
    parameter int DIV_WIDTH    = 25,
    parameter int TOTAL_TAPS   = 9,
    parameter int BITS_PER_TAP = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_enable,
    input  logic                    i_div_load,
    input  logic [DIV_WIDTH-1:0]    i_div_value,
    input  logic                    i_flush,
    input  logic [BITS_PER_TAP-1:0] i_value,
    input  logic                    i_valid,
    output logic                    o_ready,
    output logic                    o_shift_en,
    output logic [BITS_PER_TAP-1:0] o_shift_value,
    output logic                    o_taps_valid,
    output logic                    o_busy,
    output logic                    o_underrun,
    output logic                    o_LED
);
    localparam int FILL_W = $clog2(TOTAL_TAPS + 1);
    localparam logic [FILL_W-1:0] TAPS_MAX = FILL_W'(TOTAL_TAPS);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t                  state_q, state_d;
    logic [DIV_WIDTH-1:0]    div_q, div_d, cnt_q, cnt_d;
    logic [FILL_W-1:0]       fill_q, fill_d, fcnt_q, fcnt_d;
    logic                    shift_en_q, shift_en_d;
    logic                    busy_q, busy_d;
    logic                    underrun_q, underrun_d;
    logic [BITS_PER_TAP-1:0] shift_val_q, shift_val_d;
    logic                    counting, tick, run_tick;

    // The divider freezes as soon as enable drops in RUN, so a tick in that cycle is lost.
    always_comb begin
        counting = ((state_q == RUN) && i_enable) || (state_q == FLUSH);
        tick     = counting && (cnt_q == '0) && !i_div_load;
        run_tick = (state_q == RUN) && tick && !i_flush;
    end

    assign o_ready       = run_tick;
    assign o_shift_en    = shift_en_q;
    assign o_shift_value = shift_val_q;
    assign o_busy        = busy_q;
    assign o_underrun    = underrun_q;
    assign o_taps_valid  = (fill_q == TAPS_MAX);
    assign o_LED         = ~cnt_q[DIV_WIDTH-1];

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        cnt_d       = cnt_q;
        fill_d      = fill_q;
        fcnt_d      = fcnt_q;
        shift_en_d  = 1'b0;
        shift_val_d = '0;
        busy_d      = busy_q;
        underrun_d  = underrun_q;

        if (i_div_load) begin
            div_d = i_div_value;
            cnt_d = i_div_value;
        end else if (counting) begin
            cnt_d = (cnt_q == '0) ? div_q : cnt_q - 1'b1;
        end

        case (state_q)
            IDLE, RUN: begin
                if (i_flush) begin
                    // First zero shift is issued on the entry edge; fcnt counts shifts issued.
                    state_d    = FLUSH;
                    busy_d     = 1'b1;
                    shift_en_d = 1'b1;
                    fcnt_d     = FILL_W'(1);
                    fill_d     = '0;
                    underrun_d = 1'b0;
                end else if (state_q == IDLE) begin
                    if (i_enable) state_d = RUN;
                end else if (!i_enable) begin
                    state_d = IDLE;
                end else if (run_tick) begin
                    shift_en_d  = 1'b1;
                    shift_val_d = i_valid ? i_value : '0;
                    if (!i_valid) underrun_d = 1'b1;
                    if (fill_q != TAPS_MAX) fill_d = fill_q + 1'b1;
                end
            end
            FLUSH: begin
                if (fcnt_q == TAPS_MAX) begin
                    state_d = i_enable ? RUN : IDLE;
                    busy_d  = 1'b0;
                end else begin
                    shift_en_d = 1'b1;
                    fcnt_d     = fcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            div_q       <= '1;
            cnt_q       <= '1;
            fill_q      <= '0;
            fcnt_q      <= '0;
            shift_en_q  <= 1'b0;
            shift_val_q <= '0;
            busy_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            fill_q      <= fill_d;
            fcnt_q      <= fcnt_d;
            shift_en_q  <= shift_en_d;
            shift_val_q <= shift_val_d;
            busy_q      <= busy_d;
            underrun_q  <= underrun_d;
        end
    end
endmodule

// File: tb/tb_shift_line_sequencer.sv
// Scoreboard bench for shift_line_sequencer: stimulus queues expected shift values,
// a negedge monitor pops and compares them whenever o_shift_en is seen.
module tb_shift_line_sequencer;
    localparam int DW = 25;
    localparam int NT = 9;
    localparam int BW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_enable = 1'b0;
    logic          i_div_load = 1'b0;
    logic [DW-1:0] i_div_value = '0;
    logic          i_flush = 1'b0;
    logic [BW-1:0] i_value = '0;
    logic          i_valid = 1'b0;
    logic          o_ready, o_shift_en, o_taps_valid, o_busy, o_underrun, o_LED;
    logic [BW-1:0] o_shift_value;

    int            n_chk = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            prev_rc = -1;
    logic [BW-1:0] sb[$];

    shift_line_sequencer #(.DIV_WIDTH(DW), .TOTAL_TAPS(NT), .BITS_PER_TAP(BW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(i_enable), .i_div_load(i_div_load),
        .i_div_value(i_div_value), .i_flush(i_flush), .i_value(i_value), .i_valid(i_valid),
        .o_ready(o_ready), .o_shift_en(o_shift_en), .o_shift_value(o_shift_value),
        .o_taps_valid(o_taps_valid), .o_busy(o_busy), .o_underrun(o_underrun), .o_LED(o_LED)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && o_shift_en) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_shift: got shift of %0h, expected no shift", o_shift_value);
            end else begin
                chk("shift_value", 32'(o_shift_value), 32'(sb.pop_front()));
            end
        end
    end

    // Offers one sample (or a deliberate gap) and waits for the tick that takes it.
    task automatic send(input logic vld, input logic [BW-1:0] v, input bit per_chk, output int rc);
        int n = 0;
        i_valid = vld;
        i_value = v;
        while (!o_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_seen", 32'(o_ready), 1);
        rc = cyc;
        if (o_ready) sb.push_back(vld ? v : '0);
        if (per_chk) chk("ready_period", 32'(rc - prev_rc), 4);
        prev_rc = rc;
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic flush_check();
        int n = 0;
        chk("flush_busy_entry", 32'(o_busy), 1);
        chk("flush_taps_valid", 32'(o_taps_valid), 0);
        chk("flush_underrun_clr", 32'(o_underrun), 0);
        while (o_busy && n < 20) begin
            chk("flush_shift_en", 32'(o_shift_en), 1);
            chk("flush_ready", 32'(o_ready), 0);
            n++;
            @(posedge clk); #1;
        end
        chk("flush_len", 32'(n), NT);
        chk("flush_sb_drained", 32'(sb.size()), 0);
        prev_rc = -1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rc, t0, n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(o_ready), 0);
        chk("rst_shift_en", 32'(o_shift_en), 0);
        chk("rst_shift_value", 32'(o_shift_value), 0);
        chk("rst_taps_valid", 32'(o_taps_valid), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_underrun", 32'(o_underrun), 0);
        chk("rst_led", 32'(o_LED), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        i_div_value = 25'd3;
        i_div_load  = 1'b1;
        @(posedge clk); #1;
        i_div_load = 1'b0;
        i_enable   = 1'b1;

        // Fill the line with 1..9.
        for (int i = 1; i <= 9; i++) begin
            send(1'b1, 8'(i), i > 1, rc);
            chk("fill_taps_valid", 32'(o_taps_valid), 32'(i == 9));
            chk("fill_no_underrun", 32'(o_underrun), 0);
        end

        // Underrun: a tick with no valid sample shifts a zero and latches the flag.
        send(1'b1, 8'h0A, 1'b1, rc);
        send(1'b0, 8'h77, 1'b1, rc);
        chk("underrun_set", 32'(o_underrun), 1);
        send(1'b1, 8'h0B, 1'b1, rc);
        chk("underrun_sticky", 32'(o_underrun), 1);
        chk("full_taps_valid", 32'(o_taps_valid), 1);

        // Flush from a full line.
        i_flush = 1'b1;
        repeat (NT) sb.push_back('0);
        @(posedge clk); #1;
        i_flush = 1'b0;
        flush_check();

        // Ticks resume; a gap still counts toward fill.
        for (int i = 0; i < 9; i++) begin
            send(i != 4, 8'(8'h30 + i), i > 0, rc);
            chk("refill_taps_valid", 32'(o_taps_valid), 32'(i == 8));
        end
        chk("refill_underrun", 32'(o_underrun), 1);

        // Flush coinciding with a tick and a valid sample: sample must be refused.
        i_valid = 1'b1;
        i_value = 8'h55;
        n = 0;
        while (!o_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("tick_before_flush", 32'(o_ready), 1);
        i_flush = 1'b1;
        #1;
        chk("ready_masked_by_flush", 32'(o_ready), 0);
        repeat (NT) sb.push_back('0);
        @(posedge clk); #1;
        i_flush = 1'b0;
        i_valid = 1'b0;
        flush_check();

        // Enable drop after 4 shifts: fill and divider hold while idle.
        for (int i = 1; i <= 4; i++) send(1'b1, 8'(8'h40 + i), i > 1, rc);
        i_enable = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            chk("ready_while_idle", 32'(o_ready), 0);
        end
        chk("idle_taps_valid", 32'(o_taps_valid), 0);
        t0 = cyc;
        i_enable = 1'b1;
        send(1'b1, 8'h45, 1'b0, rc);
        chk("resume_latency", 32'(rc - t0), 4);
        chk("resume_taps_valid", 32'(o_taps_valid), 0);
        for (int i = 6; i <= 9; i++) begin
            send(1'b1, 8'(8'h40 + i), 1'b1, rc);
            chk("resume_fill_taps_valid", 32'(o_taps_valid), 32'(i == 9));
        end

        // Asynchronous reset in the middle of a flush.
        i_flush = 1'b1;
        repeat (NT) sb.push_back('0);
        @(posedge clk); #1;
        i_flush = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("pre_reset_busy", 32'(o_busy), 1);
        chk("pre_reset_led", 32'(o_LED), 1);
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("arst_shift_en", 32'(o_shift_en), 0);
        chk("arst_shift_value", 32'(o_shift_value), 0);
        chk("arst_busy", 32'(o_busy), 0);
        chk("arst_ready", 32'(o_ready), 0);
        chk("arst_taps_valid", 32'(o_taps_valid), 0);
        chk("arst_underrun", 32'(o_underrun), 0);
        chk("arst_led", 32'(o_LED), 0);
        i_enable = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("post_rst_div_reg", 32'(dut.div_q), 32'h1FF_FFFF);
        chk("post_rst_counter", 32'(dut.cnt_q), 32'h1FF_FFFF);
        chk("post_rst_busy", 32'(o_busy), 0);
        chk("post_rst_shift_en", 32'(o_shift_en), 0);
        chk("post_rst_ready", 32'(o_ready), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/shift_line_sequencer.md
Name: shift_line_sequencer

Overview:
Controller that schedules when the tap shift-register line shifts, and what value it shifts in. It divides i_clk down to a programmable sample tick and accepts one streamed sample per tick over a valid/ready handshake. It drives the line's shift-enable and data, tracks fill level so downstream filter logic knows when all taps hold real samples, and provides a zero-flush sequence. The block sits between the sample source and the tap line, replacing the line's free-running strobe.

Parameters:
DIV_WIDTH, 25, width of sample-rate divider and counter.
TOTAL_TAPS, 9, taps in the controlled line; bounds the fill counter and flush length.
BITS_PER_TAP, 8, sample width.

Ports:
i_clk  in  1  clock; all logic on rising edge.
i_rst_n  in  1  asynchronous active-low reset.
i_enable  in  1  run enable; low = IDLE.
i_div_load  in  1  one-cycle pulse; loads i_div_value.
i_div_value  in  DIV_WIDTH  tick period minus 1.
i_flush  in  1  one-cycle pulse; starts zero-flush.
i_value  in  BITS_PER_TAP  streamed sample.
i_valid  in  1  i_value valid.
o_ready  out  1  sample accepted this cycle when i_valid && o_ready.
o_shift_en  out  1  one-cycle shift pulse to tap line.
o_shift_value  out  BITS_PER_TAP  value to shift in; meaningful only with o_shift_en.
o_taps_valid  out  1  high when fill == TOTAL_TAPS.
o_busy  out  1  high in FLUSH.
o_underrun  out  1  sticky; a tick found no valid sample.
o_LED  out  1  heartbeat = !counter[DIV_WIDTH-1].

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; div_reg and counter = all ones; fill=0.
  - o_underrun, o_shift_en, o_busy = 0; o_shift_value=0.
  - o_taps_valid=0; o_ready=0.
- Divider:
  - Counter counts down only in RUN or FLUSH.
  - At 0 it reloads from div_reg and raises tick, valid for that cycle only.
  - Tick period = div_reg+1 cycles. div_reg=0 gives a tick every cycle.
  - i_div_load (any state): div_reg and counter <= i_div_value; no tick in the load cycle.
- States: IDLE, RUN, FLUSH.
  - IDLE -> RUN when i_enable=1 and no flush.
  - RUN -> IDLE when i_enable=0, taking effect at the next edge. Counter is held, fill preserved, and a pending tick in that cycle is dropped.
  - IDLE or RUN -> FLUSH on i_flush. i_flush has priority over a tick and over a handshake in the same cycle; the sample is not accepted.
  - FLUSH -> RUN (i_enable=1) or IDLE after TOTAL_TAPS shifts.
- RUN tick handling:
  - o_ready = (state==RUN) && tick && !i_flush, combinational.
  - If i_valid: capture i_value. The next cycle gives o_shift_en=1 and o_shift_value=captured. Latency 1 cycle from handshake.
  - If !i_valid: the next cycle gives o_shift_en=1 and o_shift_value=0, and o_underrun is set. Sample timing is preserved.
  - Each shift increments fill, saturating at TOTAL_TAPS.
- FLUSH:
  - o_busy=1 and o_ready=0.
  - o_shift_en=1 with value 0 on each of TOTAL_TAPS consecutive cycles, starting the cycle after entry and ignoring the divider.
  - fill cleared to 0 on entry; o_underrun cleared on entry.
  - i_flush during FLUSH is ignored; i_enable is sampled only at exit.
  - Divider keeps counting; ticks during FLUSH are discarded.
- Registered outputs: o_shift_en, o_shift_value, o_busy, o_underrun. o_taps_valid decodes the fill register.
- Reset mid-FLUSH or mid-shift aborts immediately to reset values.

Test Plan:
- Reset then enable, div_value=3, i_valid held 1 with values 1..9: o_ready pulses every 4 cycles. o_shift_en follows 1 cycle later with matching value. o_taps_valid rises with the 9th shift.
- div_value=3, i_valid=0 at the 2nd tick: o_shift_en with value 0, o_underrun=1 and stays 1. Fill still increments.
- Full line (fill=9), pulse i_flush: o_busy=1 for exactly 9 cycles, with 9 zero shifts on consecutive cycles. o_taps_valid=0 from entry, o_underrun cleared. Returns to RUN and ticks resume.
- i_flush in the same cycle as tick with i_valid=1: o_ready=0, sample not accepted, FLUSH entered.
- Drop i_enable after 4 shifts for 20 cycles, then raise it: no shifts or o_ready while low. Fill stays 4 and the counter resumes from its held value.
- Assert i_rst_n=0 asynchronously mid-FLUSH (no clock edge): all outputs 0 immediately. After release, state is IDLE and div_reg is all ones.
